// File: rtl/fpdiv_pkg.sv
// Shared types and defaults for the fpdiv divider/sqrt unit: sequencer states,
// iteration-count defaults and the rounding-mode encodings used by the datapath.
`timescale 1ps/1ps
package fpdiv_pkg;

  localparam int ITER_SP_DEF     = 3;  // Goldschmidt iterations, single precision
  localparam int ITER_DP_DEF     = 4;  // Goldschmidt iterations, double precision
  localparam int ITER_CYCLES_DEF = 2;  // multiplier latency per iteration
  localparam int CNT_W_DEF       = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RND_NEAREST_EVEN = 2'd0,
    RND_TO_ZERO      = 2'd1,
    RND_TO_POS_INF   = 2'd2,
    RND_TO_NEG_INF   = 2'd3
  } rnd_mode_e;

  // Decoded control strobes towards the datapath.
  typedef struct packed {
    logic op_ld;
    logic mul_en;
    logic sel_init;
    logic iter_last;
    logic round_en;
    logic busy;
    logic done;
  } ctrl_out_t;

endpackage

// File: rtl/fpdiv_iter_cnt.sv
// Loadable down-counter for the Goldschmidt iteration cycles; tc flags a count of zero.
`timescale 1ps/1ps
module fpdiv_iter_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: every variable gets its default first so no branch can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '0);

endmodule

// File: rtl/fpdiv_ctrl.sv
// Start/done sequencer for fpdiv: accepts a start edge, latches P/op_type and steps the
// Goldschmidt datapath through LOAD, the multiply iterations and the rounding cycle.
`timescale 1ps/1ps
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITER_SP     = ITER_SP_DEF,
  parameter int ITER_DP     = ITER_DP_DEF,
  parameter int ITER_CYCLES = ITER_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic P,
  input  logic op_type,
  output logic op_ld,
  output logic mul_en,
  output logic sel_init,
  output logic iter_last,
  output logic round_en,
  output logic busy,
  output logic done,
  output logic p_q,
  output logic op_type_q
);

  localparam int TOT_SP = ITER_SP * ITER_CYCLES;
  localparam int TOT_DP = ITER_DP * ITER_CYCLES;
  localparam logic [CNT_W-1:0] TOP_SP = CNT_W'(TOT_SP - 1);
  localparam logic [CNT_W-1:0] TOP_DP = CNT_W'(TOT_DP - 1);

  generate
    if ((TOT_DP > 2**CNT_W) || (TOT_SP > 2**CNT_W) || (TOT_SP < 1) || (TOT_DP < 1)) begin : g_cnt_w_check
      $error("fpdiv_ctrl: CNT_W too narrow for ITER_DP*ITER_CYCLES");
    end
  endgenerate

  state_e    state_d, state_q;
  logic      start_d, start_q;
  logic      p_d, op_type_d;
  ctrl_out_t ctl;

  logic             acc;
  logic             cnt_clr, cnt_load, cnt_en;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic [CNT_W-1:0] iter_top;

  // A start held high is one request: only the rising edge is accepted.
  assign acc = start & ~start_q;

  // The counter is loaded at the LOAD exit edge, with the same P that p_q captures there.
  assign cnt_load     = (state_q == LOAD);
  assign cnt_load_val = P ? TOP_SP : TOP_DP;
  assign cnt_en       = (state_q == ITER);
  assign cnt_clr      = (state_q == ROUND);
  assign iter_top     = p_q ? TOP_SP : TOP_DP;

  fpdiv_iter_cnt #(
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    start_d   = start;
    p_d       = p_q;
    op_type_d = op_type_q;
    ctl       = '0;
    unique case (state_q)
      IDLE: begin
        if (acc) state_d = LOAD;
      end
      LOAD: begin
        ctl.op_ld = 1'b1;
        ctl.busy  = 1'b1;
        p_d       = P;
        op_type_d = op_type;
        state_d   = ITER;
      end
      ITER: begin
        ctl.mul_en    = 1'b1;
        ctl.busy      = 1'b1;
        ctl.sel_init  = (cnt == iter_top);
        ctl.iter_last = cnt_tc;
        if (cnt_tc) state_d = ROUND;
      end
      ROUND: begin
        ctl.round_en = 1'b1;
        ctl.busy     = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        ctl.done = 1'b1;
        if (acc) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      p_q       <= 1'b0;
      op_type_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      p_q       <= p_d;
      op_type_q <= op_type_d;
    end
  end

  // Strobes decode from state only, so reset clears them without waiting for a clock.
  assign op_ld     = ctl.op_ld;
  assign mul_en    = ctl.mul_en;
  assign sel_init  = ctl.sel_init;
  assign iter_last = ctl.iter_last;
  assign round_en  = ctl.round_en;
  assign busy      = ctl.busy;
  assign done      = ctl.done;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboard bench for fpdiv_ctrl: requests push expected timing, a negedge monitor
// pops on op_ld and compares every strobe against the request's cycle offsets.
`timescale 1ps/1ps
module tb_fpdiv_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic P = 1'b0;
  logic op_type = 1'b0;
  logic op_ld, mul_en, sel_init, iter_last, round_en, busy, done, p_q, op_type_q;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  // One request: edge count at which it is accepted, ITER length in cycles, latched modes.
  typedef struct {
    int   e0;
    int   n;
    logic p;
    logic op;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 1'b0;

  fpdiv_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .P         (P),
    .op_type   (op_type),
    .op_ld     (op_ld),
    .mul_en    (mul_en),
    .sel_init  (sel_init),
    .iter_last (iter_last),
    .round_en  (round_en),
    .busy      (busy),
    .done      (done),
    .p_q       (p_q),
    .op_type_q (op_type_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a negedge with the DUT idle/done and start low: accepted at the next edge.
  task automatic issue(input logic p, input logic op);
    exp_t e;
    start   = 1'b1;
    P       = p;
    op_type = op;
    e.e0    = cyc + 1;
    e.n     = p ? 6 : 8;
    e.p     = p;
    e.op    = op;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", done, 1);
  endtask

  always @(negedge clk) begin
    logic [6:0] act;
    logic [6:0] expv;
    int         rel;
    act = {op_ld, busy, done, mul_en, sel_init, iter_last, round_en};
    if (reset) begin
      have_cur = 1'b0;
      check("outputs_in_reset", {act, p_q, op_type_q}, 0);
    end else begin
      if (op_ld) begin
        if (exp_q.size() == 0) begin
          check("op_ld_without_request", op_ld, 0);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          check("op_ld_cycle", cyc, cur.e0);
        end
      end
      expv = '0;
      if (have_cur) begin
        rel  = cyc - cur.e0;
        expv = {rel == 0,
                rel >= 0 && rel <= cur.n + 1,
                rel >= cur.n + 2,
                rel >= 1 && rel <= cur.n,
                rel == 1,
                rel == cur.n,
                rel == cur.n + 1};
        if (rel >= 1) begin
          check("p_q_latched", p_q, cur.p);
          check("op_type_q_latched", op_type_q, cur.op);
        end
      end
      check("strobes{op_ld,busy,done,mul,sel,last,rnd}", act, expv);
      check("busy_and_done_exclusive", busy & done, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset, then idle with start low.
    #27 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {op_ld, mul_en, sel_init, iter_last, round_en, busy, done, p_q, op_type_q}, 0);
    end

    // Single precision, start held for two edges.
    @(negedge clk);
    issue(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(15);
    repeat (4) @(negedge clk);

    // Double precision sqrt; P toggles mid-ITER without effect.
    issue(1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    P = 1'b1;
    op_type = 1'b0;
    wait_done(15);
    P = 1'b0;
    repeat (3) @(negedge clk);

    // Start pulse mid-ITER, then start held across DONE: one request only.
    issue(1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (14) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    issue(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(15);
    repeat (2) @(negedge clk);

    // Reset in the fourth ITER cycle aborts; a fresh request then runs normally.
    issue(1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset_clears_outputs",
             {op_ld, mul_en, sel_init, iter_last, round_en, busy, done, p_q, op_type_q}, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(15);
    repeat (2) @(negedge clk);

    // Back-to-back requests with random precision and operation.
    for (int i = 0; i < 100; i++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      start = 1'b0;
      wait_done(15);
    end
    repeat (3) @(negedge clk);

    check("all_requests_served", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
